// File: rtl/cordic_nco_front.sv
// Phase-accumulator front end feeding a CORDIC rotator, with a valid delay line.
// Optional angle dithering is enabled with NCO_DITHER_EN.
module cordic_nco_front #(
   parameter int BW  = 32,
   parameter int LAT = 32,
   parameter int AMP = 652032874
) (
   input  logic                 master_clk,
   input  logic                 master_rst_n,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [31:0]          cfg_freq,
   input  logic [31:0]          cfg_offset,
   input  logic                 start,
   input  logic                 stop,
   output logic [31:0]          angle,
   output logic signed [BW-1:0] xin,
   output logic signed [BW-1:0] yin,
   output logic                 in_vld,
   output logic                 out_vld,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t           state, state_n;
   logic [31:0]      acc, freq, offset, dith;
   logic [LAT-1:0]   cnt, vld_sr;
   logic             accept;

   assign accept  = cfg_valid & cfg_ready;
   assign busy    = (state != IDLE);
   assign done    = (state == DRAIN) && (cnt == LAT'(1));
   assign out_vld = vld_sr[LAT-1];
   assign xin     = BW'(AMP);
   assign yin     = '0;

`ifdef NCO_DITHER_EN
   logic [15:0] lfsr;
   logic        lfsr_fb;

   assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   assign dith    = {24'd0, lfsr[7:0]};

   always_ff @(posedge master_clk or negedge master_rst_n) begin
      if (!master_rst_n)
         lfsr <= 16'hACE1;
      else if (state == RUN)
         lfsr <= {lfsr[14:0], lfsr_fb};
   end
`else
   assign dith = 32'd0;
`endif

   always_ff @(posedge master_clk or negedge master_rst_n) begin
      if (!master_rst_n)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = RUN;
         RUN:     if (stop) state_n = DRAIN;
         DRAIN:   if (cnt == LAT'(1)) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // The stop cycle itself emits no sample; DRAIN spans exactly LAT cycles.
   always_ff @(posedge master_clk or negedge master_rst_n) begin
      if (!master_rst_n) begin
         acc       <= '0;
         freq      <= '0;
         offset    <= '0;
         angle     <= '0;
         in_vld    <= 1'b0;
         cnt       <= '0;
         vld_sr    <= '0;
         cfg_ready <= 1'b0;
      end else begin
         cfg_ready <= (state_n != DRAIN);
         vld_sr    <= {vld_sr[LAT-2:0], in_vld};
         in_vld    <= 1'b0;
         if (accept) begin
            freq   <= cfg_freq;
            offset <= cfg_offset;
         end
         case (state)
            IDLE: begin
               if (start) acc <= '0;
            end
            RUN: begin
               if (stop) begin
                  cnt <= LAT'(LAT);
               end else begin
                  angle  <= acc + offset + dith;
                  acc    <= acc + freq;
                  in_vld <= 1'b1;
               end
            end
            DRAIN: begin
               cnt <= cnt - LAT'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_nco_front.sv
// Directed self-checking bench for cordic_nco_front (default build).
module tb_cordic_nco_front;

   localparam int BW  = 32;
   localparam int LAT = 32;
   localparam int AMP = 652032874;

   logic          master_clk = 1'b0;
   logic          master_rst_n = 1'b0;
   logic          cfg_valid = 1'b0;
   logic          cfg_ready;
   logic [31:0]   cfg_freq = '0;
   logic [31:0]   cfg_offset = '0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic [31:0]   angle;
   logic [BW-1:0] xin, yin;
   logic          in_vld, out_vld, busy, done;

   int n_asrt = 0;
   int n_fail = 0;
   int cyc = 0;
   int n_in = 0;
   int n_out = 0;
   int first_in = -1;
   int first_out = -1;
   int dcyc, ndone, rdy_bad;
   logic [31:0] e;

   cordic_nco_front #(.BW(BW), .LAT(LAT), .AMP(AMP)) dut (
      .master_clk(master_clk), .master_rst_n(master_rst_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_freq(cfg_freq), .cfg_offset(cfg_offset),
      .start(start), .stop(stop), .angle(angle),
      .xin(xin), .yin(yin), .in_vld(in_vld), .out_vld(out_vld),
      .busy(busy), .done(done)
   );

   always #5 master_clk = ~master_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge master_clk);
      #1;
      cyc++;
      if (in_vld) begin
         n_in++;
         if (first_in < 0) first_in = cyc;
      end
      if (out_vld) begin
         n_out++;
         if (first_out < 0) first_out = cyc;
      end
   endtask

   task automatic clr_cnt();
      n_in = 0; n_out = 0; first_in = -1; first_out = -1;
   endtask

   task automatic drain(input int hold_start);
      dcyc = 0; ndone = 0; rdy_bad = 0;
      for (int i = 0; i < 40 && busy; i++) begin
         start = (i < hold_start);
         dcyc++;
         if (done) ndone++;
         if (cfg_ready) rdy_bad++;
         tick();
      end
      start = 1'b0;
      chk("drain_len", dcyc, 32);
      chk("done_pulses", ndone, 1);
      chk("rdy_in_drain", rdy_bad, 0);
      chk("idle_after", {31'd0, busy}, 0);
      chk("rdy_after", {31'd0, cfg_ready}, 1);
   endtask

   initial begin
      #25;
      chk("rst_angle", angle, 0);
      chk("rst_xin", xin, AMP);
      chk("rst_yin", yin, 0);
      chk("rst_ctl", {27'd0, in_vld, out_vld, busy, done, cfg_ready}, 0);
      @(negedge master_clk) master_rst_n = 1'b1;
      tick();
      chk("rdy_idle", {31'd0, cfg_ready}, 1);

      // quarter-turn stepping
      cfg_valid = 1'b1; cfg_freq = 32'h4000_0000; cfg_offset = 0;
      tick();
      cfg_valid = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("run_busy", {30'd0, busy, in_vld}, 2);
      clr_cnt();
      e = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("quad_angle", angle, e);
         chk("quad_vld", {31'd0, in_vld}, 1);
         e = e + 32'h4000_0000;
      end
      repeat (30) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop_vld", {30'd0, in_vld, busy}, 1);
      chk("stop_rdy", {31'd0, cfg_ready}, 0);
      drain(0);
      chk("n_in", n_in, 35);
      chk("n_out_eq", n_out, n_in);
      chk("out_lat", first_out, first_in + LAT);

      // offset wrap, start beats stop, start ignored in drain
      cfg_valid = 1'b1; cfg_freq = 1; cfg_offset = 32'hFFFF_FFFF;
      tick();
      cfg_valid = 1'b0; start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      chk("start_wins", {31'd0, busy}, 1);
      tick();
      chk("wrap0", angle, 32'hFFFF_FFFF);
      tick();
      chk("wrap1", angle, 32'h0000_0000);
      tick();
      chk("wrap2", angle, 32'h0000_0001);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      drain(3);

      // frequency change mid-run
      cfg_valid = 1'b1; cfg_freq = 32'h100; cfg_offset = 0;
      tick();
      cfg_valid = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("f0", angle, 32'h000);
      tick();
      chk("f1", angle, 32'h100);
      tick();
      chk("f2", angle, 32'h200);
      cfg_valid = 1'b1; cfg_freq = 32'h200;
      tick();
      cfg_valid = 1'b0;
      chk("f3", angle, 32'h300);
      tick();
      chk("f4", angle, 32'h400);
      tick();
      chk("f5", angle, 32'h600);
      tick();
      chk("f6", angle, 32'h800);

      // asynchronous reset mid-run
      master_rst_n = 1'b0;
      #1;
      chk("arst_angle", angle, 0);
      chk("arst_ctl", {28'd0, in_vld, out_vld, busy, cfg_ready}, 0);
      @(posedge master_clk);
      @(negedge master_clk) master_rst_n = 1'b1;
      clr_cnt();
      repeat (40) tick();
      chk("arst_no_out", n_out, 0);
      chk("arst_no_in", n_in, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
